aes_wb_master: RTL and testbench

AES_WB_MASTER -- requirements
Module: aes_wb_master

---
 rtl/aes_wb_master_if.sv | 25 ++
 rtl/aes_wb_master.sv | 237 +++++++++++++++++++++++
 tb/tb_aes_wb_master.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_wb_master_if.sv
// aes_wb_master_if: Wishbone B4 classic bus between the AES job master and the AES core register block.
`default_nettype none

interface aes_wb_master_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

`default_nettype wire

// File: rtl/aes_wb_master.sv
// aes_wb_master: runs one AES job over Wishbone (load key/text, start, poll done, read ciphertext).
// Optional AES_WBM_READBACK_EN: read back and verify every KEY_n/TXT_n write. Rev 1.0
`default_nettype none

module aes_wb_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          POLL_GAP  = 8,
  parameter int          TIMEOUT   = 1024
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          start_i,
  input  logic [127:0]  key_i,
  input  logic [127:0]  text_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [127:0]  result_o,
  aes_wb_master_if.master wbm
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WRITE     = 3'd1;
  localparam logic [2:0] POLL_WAIT = 3'd2;
  localparam logic [2:0] POLL_READ = 3'd3;
  localparam logic [2:0] READ      = 3'd4;
  localparam logic [2:0] FINISH    = 3'd5;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
  localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);
  localparam logic [3:0]  LAST_WR   = 4'd11;

  logic [2:0]   state;
  logic [3:0]   step;
  logic         rb;
  logic [127:0] key_q;
  logic [127:0] text_q;
  logic [15:0]  poll_cnt;
  logic [15:0]  gap_cnt;
  logic         cyc;
  logic         stb;
  logic         we;
  logic [3:0]   sel;
  logic [31:0]  adr;
  logic [31:0]  dat;

  logic [7:0]   wr_off;
  logic [31:0]  wr_data;
  logic [7:0]   rd_off;
  logic         is_data_step;
  logic         rb_pending;
  logic         rb_bad;

  assign wbm.wbm_cyc_o = cyc;
  assign wbm.wbm_stb_o = stb;
  assign wbm.wbm_we_o  = we;
  assign wbm.wbm_sel_o = sel;
  assign wbm.wbm_adr_o = adr;
  assign wbm.wbm_dat_o = dat;

  // Write sequence: CTRL=0, CTRL=1, KEY_4..KEY_1, TXT_4..TXT_1, CTRL=3, CTRL=1
  always_comb begin
    wr_off  = 8'h00;
    wr_data = 32'h0;
    case (step)
      4'd0:    wr_data = 32'h0;
      4'd1:    wr_data = 32'h1;
      4'd2:    begin wr_off = 8'h10; wr_data = key_q[127:96];  end
      4'd3:    begin wr_off = 8'h0C; wr_data = key_q[95:64];   end
      4'd4:    begin wr_off = 8'h08; wr_data = key_q[63:32];   end
      4'd5:    begin wr_off = 8'h04; wr_data = key_q[31:0];    end
      4'd6:    begin wr_off = 8'h20; wr_data = text_q[127:96]; end
      4'd7:    begin wr_off = 8'h1C; wr_data = text_q[95:64];  end
      4'd8:    begin wr_off = 8'h18; wr_data = text_q[63:32];  end
      4'd9:    begin wr_off = 8'h14; wr_data = text_q[31:0];   end
      4'd10:   wr_data = 32'h3;
      4'd11:   wr_data = 32'h1;
      default: wr_data = 32'h0;
    endcase
  end

  assign rd_off       = 8'h20 - {4'h0, step[1:0], 2'b00};
  assign is_data_step = (step >= 4'd2) && (step <= 4'd9);

`ifdef AES_WBM_READBACK_EN
  assign rb_pending = !rb && is_data_step;
  assign rb_bad     = rb && (wbm.wbm_dat_i != wr_data);
`else
  assign rb_pending = 1'b0;
  assign rb_bad     = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state    <= IDLE;
      step     <= 4'd0;
      rb       <= 1'b0;
      key_q    <= 128'h0;
      text_q   <= 128'h0;
      poll_cnt <= 16'h0;
      gap_cnt  <= 16'h0;
      cyc      <= 1'b0;
      stb      <= 1'b0;
      we       <= 1'b0;
      sel      <= 4'h0;
      adr      <= 32'h0;
      dat      <= 32'h0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      result_o <= 128'h0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            key_q  <= key_i;
            text_q <= text_i;
            busy_o <= 1'b1;
            step   <= 4'd0;
            rb     <= 1'b0;
            state  <= WRITE;
          end
        end

        WRITE: begin
          if (!cyc) begin
            cyc <= 1'b1;
            stb <= 1'b1;
            sel <= 4'hF;
            we  <= !rb;
            adr <= BASE_ADDR + {24'h0, wr_off};
            dat <= rb ? 32'h0 : wr_data;
          end else if (wbm.wbm_ack_i) begin
            cyc <= 1'b0;
            stb <= 1'b0;
            we  <= 1'b0;
            if (rb_pending) begin
              rb <= 1'b1;
            end else if (rb_bad) begin
              state  <= FINISH;
              done_o <= 1'b1;
              busy_o <= 1'b0;
              err_o  <= 1'b1;
            end else begin
              rb <= 1'b0;
              if (step == LAST_WR) begin
                step     <= 4'd0;
                poll_cnt <= 16'h0;
                gap_cnt  <= 16'h0;
                state    <= POLL_WAIT;
              end else begin
                step <= step + 4'd1;
              end
            end
          end
        end

        POLL_WAIT: begin
          poll_cnt <= poll_cnt + 16'd1;
          if (poll_cnt >= TIMEOUT_W) begin
            state  <= FINISH;
            done_o <= 1'b1;
            busy_o <= 1'b0;
            err_o  <= 1'b1;
          end else if (gap_cnt >= GAP_LAST) begin
            gap_cnt <= 16'h0;
            state   <= POLL_READ;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end

        POLL_READ: begin
          poll_cnt <= poll_cnt + 16'd1;
          if (!cyc) begin
            cyc <= 1'b1;
            stb <= 1'b1;
            sel <= 4'hF;
            we  <= 1'b0;
            adr <= BASE_ADDR;
            dat <= 32'h0;
          end else if (wbm.wbm_ack_i) begin
            cyc <= 1'b0;
            stb <= 1'b0;
            // The poll read finishes even past the deadline so the bus is never cut mid-transfer
            if (wbm.wbm_dat_i[2]) begin
              step  <= 4'd0;
              state <= READ;
            end else if (poll_cnt >= TIMEOUT_W) begin
              state  <= FINISH;
              done_o <= 1'b1;
              busy_o <= 1'b0;
              err_o  <= 1'b1;
            end else begin
              state <= POLL_WAIT;
            end
          end
        end

        READ: begin
          if (!cyc) begin
            cyc <= 1'b1;
            stb <= 1'b1;
            sel <= 4'hF;
            we  <= 1'b0;
            adr <= BASE_ADDR + {24'h0, rd_off};
            dat <= 32'h0;
          end else if (wbm.wbm_ack_i) begin
            cyc <= 1'b0;
            stb <= 1'b0;
            case (step[1:0])
              2'd0:    result_o[127:96] <= wbm.wbm_dat_i;
              2'd1:    result_o[95:64]  <= wbm.wbm_dat_i;
              2'd2:    result_o[63:32]  <= wbm.wbm_dat_i;
              default: result_o[31:0]   <= wbm.wbm_dat_i;
            endcase
            if (step[1:0] == 2'd3) begin
              state  <= FINISH;
              done_o <= 1'b1;
              busy_o <= 1'b0;
              err_o  <= 1'b0;
            end else begin
              step <= step + 4'd1;
            end
          end
        end

        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_wb_master.sv
// tb_aes_wb_master: randomized bench with a register-level AES core model on the Wishbone side.
`default_nettype none

module tb_aes_wb_master;

  localparam logic [31:0]  BASE     = 32'h4000_0100;
  localparam int           POLL_GAP = 4;
  localparam int           TIMEOUT  = 64;
  localparam logic [127:0] V1K = 128'h4f2f8b71e8c5340f0b21fd95af7fe629;
  localparam logic [127:0] V1T = 128'h436f620f120bce3cd275a91df918d31d;
  localparam logic [127:0] V1R = 128'haaaa92503215c96bb93e66d7a6c32e90;
  localparam logic [127:0] V2K = 128'ha51e73925c9b57d14d48e24266909825;
  localparam logic [127:0] V2T = 128'h01203d5b5b589cbc46115c899d069dab;
  localparam logic [127:0] V2R = 128'h3e9bcfb49af4cea5d589dee62e79fedd;
`ifdef AES_WBM_READBACK_EN
  localparam int EXP_DATA_READS = 12;
`else
  localparam int EXP_DATA_READS = 4;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] text = '0;
  logic         busy, done, err;
  logic [127:0] result;

  aes_wb_master_if bus();

  aes_wb_master #(.BASE_ADDR(BASE), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .start_i  (start),
    .key_i    (key),
    .text_i   (text),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err),
    .result_o (result),
    .wbm      (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stand-in for the cipher: known vectors map to their ciphertext, anything else to a fixed mix
  function automatic logic [127:0] ref_cipher(input logic [127:0] k, input logic [127:0] t);
    if (k == V1K && t == V1T) return V1R;
    if (k == V2K && t == V2T) return V2R;
    return {k[63:0] ^ t[127:64], k[127:64] + t[63:0]};
  endfunction

  typedef struct { logic [31:0] adr; logic [31:0] dat; } wr_t;

  // Expected single-write sequence of one job
  function automatic void expected_writes(input logic [127:0] k, input logic [127:0] t, output wr_t q[$]);
    q = {};
    q.push_back('{BASE, 32'h0});
    q.push_back('{BASE, 32'h1});
    for (int i = 0; i < 4; i++) q.push_back('{BASE + 32'h10 - 32'(4 * i), k[127 - 32 * i -: 32]});
    for (int i = 0; i < 4; i++) q.push_back('{BASE + 32'h20 - 32'(4 * i), t[127 - 32 * i -: 32]});
    q.push_back('{BASE, 32'h3});
    q.push_back('{BASE, 32'h1});
  endfunction

  // Core register model and transfer bookkeeping
  logic [31:0]  regs [0:8];
  logic [1:0]   ctrl_bits;
  bit           done_flag, pending, never_done, hold_ack, corrupt_rb;
  int           lat, max_delay, wait_left, reads_data, xfer_starts;
  bit           in_xfer, started_now;
  logic [31:0]  sadr, sdat;
  logic         swe;
  logic [127:0] pend_res;
  wr_t          writes[$];
  longint       cyc_no = 0;
  longint       first_poll = -1;
  longint       last_done_cyc = 0;

  always @(posedge clk) cyc_no++;

  task automatic slave_op();
    int idx;
    idx = int'((bus.wbm_adr_o - BASE) >> 2);
    if (bus.wbm_we_o) begin
      writes.push_back('{bus.wbm_adr_o, bus.wbm_dat_o});
      if (idx == 0) begin
        ctrl_bits = bus.wbm_dat_o[1:0];
        if (bus.wbm_dat_o == 32'h0) done_flag = 1'b0;
        if (bus.wbm_dat_o[1] && !never_done) begin
          pending  = 1'b1;
          lat      = int'($urandom_range(5, 25));
          pend_res = ref_cipher({regs[4], regs[3], regs[2], regs[1]}, {regs[8], regs[7], regs[6], regs[5]});
        end
      end else if (idx <= 8) begin
        regs[idx] = bus.wbm_dat_o;
      end
    end else begin
      if (idx == 0) begin
        bus.wbm_dat_i = {29'h0, done_flag, ctrl_bits};
      end else begin
        reads_data++;
        bus.wbm_dat_i = (corrupt_rb && !done_flag) ? ~regs[idx] : regs[idx];
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wbm_ack_i) begin
        bus.wbm_ack_i = 1'b0;
        check_val("cyc_drop_after_ack", {126'h0, bus.wbm_cyc_o, bus.wbm_stb_o}, 128'h0);
      end else if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
        started_now = 1'b0;
        if (!in_xfer) begin
          in_xfer     = 1'b1;
          started_now = 1'b1;
          xfer_starts++;
          wait_left   = int'($urandom_range(0, max_delay));
          sadr = bus.wbm_adr_o; sdat = bus.wbm_dat_o; swe = bus.wbm_we_o;
          check_val("sel", {124'h0, bus.wbm_sel_o}, 128'hF);
          if (!bus.wbm_we_o && bus.wbm_adr_o == BASE && first_poll < 0) first_poll = cyc_no;
        end
        if (!hold_ack) begin
          if (wait_left == 0) begin
            if (!started_now)
              check_val("held_until_ack", {63'h0, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o},
                        {63'h0, swe, sadr, sdat});
            in_xfer = 1'b0;
            slave_op();
            bus.wbm_ack_i = 1'b1;
          end else begin
            wait_left--;
          end
        end
      end
      if (pending) begin
        if (lat == 0) begin
          pending   = 1'b0;
          done_flag = 1'b1;
          regs[8] = pend_res[127:96]; regs[7] = pend_res[95:64];
          regs[6] = pend_res[63:32];  regs[5] = pend_res[31:0];
        end else begin
          lat--;
        end
      end
    end
  end

  task automatic slave_reset();
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'h0;
    in_xfer = 1'b0; pending = 1'b0; done_flag = 1'b0; hold_ack = 1'b0;
    ctrl_bits = 2'b00;
    for (int i = 0; i < 9; i++) regs[i] = 32'h0;
  endtask

  task automatic run_job(input logic [127:0] k, input logic [127:0] t, input bit flood,
                         input bit check_seq, input logic exp_err, input logic [127:0] exp_res,
                         input string tag);
    bit  seen;
    wr_t exp_q[$];
    writes.delete();
    reads_data = 0;
    first_poll = -1;
    @(negedge clk);
    key = k; text = t; start = 1'b1;
    @(negedge clk);
    check_val({tag, "_busy"}, {127'h0, busy}, 128'h1);
    if (!flood) start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin seen = 1'b1; break; end
      if (flood) key = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    check_val({tag, "_done_seen"}, {127'h0, seen}, 128'h1);
    if (seen) begin
      last_done_cyc = cyc_no;
      check_val({tag, "_err"}, {127'h0, err}, {127'h0, exp_err});
      check_val({tag, "_result"}, result, exp_res);
      check_val({tag, "_busy_clear"}, {127'h0, busy}, 128'h0);
      @(negedge clk);
      start = 1'b0;
      check_val({tag, "_done_pulse"}, {127'h0, done}, 128'h0);
      check_val({tag, "_finish_start_ignored"}, {127'h0, busy}, 128'h0);
      repeat (3) @(negedge clk);
      check_val({tag, "_stays_idle"}, {126'h0, busy, bus.wbm_cyc_o}, 128'h0);
      if (check_seq) begin
        expected_writes(k, t, exp_q);
        check_val({tag, "_write_count"}, 128'(writes.size()), 128'(exp_q.size()));
        if (writes.size() == exp_q.size())
          for (int i = 0; i < exp_q.size(); i++)
            check_val({tag, "_write"}, {64'h0, writes[i].adr, writes[i].dat}, {64'h0, exp_q[i].adr, exp_q[i].dat});
        if (!exp_err) check_val({tag, "_data_reads"}, 128'(reads_data), 128'(EXP_DATA_READS));
      end
    end else begin
      start = 1'b0;
    end
  endtask

  initial begin
    logic [127:0] rk, rt, prev;
    bit           seen;
    int           starts_snap;
    never_done = 1'b0; corrupt_rb = 1'b0; max_delay = 0; xfer_starts = 0;
    slave_reset();

    repeat (3) @(negedge clk);
    check_val("reset_outputs", {busy, done, err, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o},  128'h0);
    check_val("reset_result", result, 128'h0);
    check_val("reset_bus", {bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o}, 128'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_job(V1K, V1T, 1'b0, 1'b1, 1'b0, V1R, "vec1");
    run_job(V1K, V1T, 1'b0, 1'b1, 1'b0, V1R, "b2b_a");
    run_job(V2K, V2T, 1'b0, 1'b1, 1'b0, V2R, "b2b_b");

    max_delay = 5;
    run_job(V1K, V1T, 1'b0, 1'b1, 1'b0, V1R, "vec1_slow_ack");
    for (int n = 0; n < 5; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rt = {$urandom, $urandom, $urandom, $urandom};
      run_job(rk, rt, 1'b0, 1'b1, 1'b0, ref_cipher(rk, rt), "rand");
    end

    rk = {$urandom, $urandom, $urandom, $urandom};
    rt = {$urandom, $urandom, $urandom, $urandom};
    run_job(rk, rt, 1'b1, 1'b1, 1'b0, ref_cipher(rk, rt), "flood");

    max_delay = 0;
    never_done = 1'b1;
    prev = result;
    run_job(V2K, V2T, 1'b0, 1'b1, 1'b1, prev, "timeout");
    check_val("timeout_polled", {127'h0, first_poll >= 0}, 128'h1);
    check_val("timeout_bound", {127'h0, (last_done_cyc - first_poll) <= longint'(TIMEOUT + POLL_GAP + 2)}, 128'h1);
    never_done = 1'b0;

    run_job(V2K, V2T, 1'b0, 1'b1, 1'b0, V2R, "after_err");

`ifdef AES_WBM_READBACK_EN
    corrupt_rb = 1'b1;
    prev = result;
    run_job(V1K, V1T, 1'b0, 1'b0, 1'b1, prev, "rb_mismatch");
    corrupt_rb = 1'b0;
`endif

    hold_ack = 1'b1;
    @(negedge clk);
    key = V1K; text = V1T; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.wbm_cyc_o) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check_val("rst_cyc_seen", {127'h0, seen}, 128'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_async_bus", {125'h0, bus.wbm_cyc_o, bus.wbm_stb_o, busy}, 128'h0);
    check_val("rst_async_outputs", {err, done, result[126:0]}, 128'h0);
    slave_reset();
    @(negedge clk);
    rst_n = 1'b1;
    starts_snap = xfer_starts;
    repeat (50) @(negedge clk);
    check_val("rst_no_resume", 128'(xfer_starts), 128'(starts_snap));
    check_val("rst_idle", {126'h0, busy, bus.wbm_cyc_o}, 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
